// File: rtl/qspi_read_master.sv
// QSPI flash read master: command, address, optional dummy and 1/2/4-lane data with stream backpressure.
// Define QSPI_QUAD_EN to enable the quad (0x6B) transaction; otherwise mode 3 runs as dual output.
module qspi_read_master #(
    parameter int unsigned ADDR_W    = 24,
    parameter int unsigned DUMMY_CYC = 8,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned CSN_HOLD  = 4
) (
    input  logic              qspi_clk,
    input  logic              rst,
    input  logic              req,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    output logic              ack,
    output logic              busy,
    output logic              done,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              sck,
    output logic              csn,
    output logic [3:0]        io_o,
    output logic [3:0]        io_oe,
    input  logic [3:0]        io_i
);

    localparam int unsigned SR_W  = 8 + ADDR_W;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_END} state_t;

    state_t            state_q, state_d;
    logic              phase_q, phase_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [1:0]        mode_q, mode_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [6:0]        rx_q, rx_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              ack_q, ack_d, busy_q, busy_d, done_q, done_d;
    logic              sck_q, sck_d, csn_q, csn_d;
    logic [3:0]        io_o_q, io_o_d, io_oe_q, io_oe_d;

    logic [1:0]        mode_eff_c;
    logic [7:0]        opcode_c;
    logic [7:0]        rx_shift_c;
    logic [CNT_W-1:0]  bpb_last_c;
    logic [SR_W-1:0]   sr_shift_c;

`ifdef QSPI_QUAD_EN
    assign mode_eff_c = mode;
`else
    assign mode_eff_c = (mode == 2'd3) ? 2'd2 : mode;
`endif

    // Opcode, per-SCK receive shift and SCKs-per-byte for the selected lane mode
    always_comb begin
        case (mode_eff_c)
            2'd0:    opcode_c = 8'h03;
            2'd1:    opcode_c = 8'h0B;
            2'd2:    opcode_c = 8'h3B;
            default: opcode_c = 8'h6B;
        endcase
        case (mode_q)
            2'd2: begin
                rx_shift_c = {rx_q[5:0], io_i[1:0]};
                bpb_last_c = CNT_W'(3);
            end
            2'd3: begin
                rx_shift_c = {rx_q[3:0], io_i};
                bpb_last_c = CNT_W'(1);
            end
            default: begin
                rx_shift_c = {rx_q, io_i[1]};
                bpb_last_c = CNT_W'(7);
            end
        endcase
        sr_shift_c = {sr_q[SR_W-2:0], 1'b0};
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        mode_d     = mode_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        rx_d       = rx_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q & ~rd_ready;
        ack_d      = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sck_d      = sck_q;
        csn_d      = csn_q;
        io_o_d     = io_o_q;
        io_oe_d    = io_oe_q;

        case (state_q)
            S_IDLE: begin
                // Previous burst's last byte must be consumed before a new request
                if (req && !rd_valid_q) begin
                    state_d    = S_CMD;
                    ack_d      = 1'b1;
                    busy_d     = 1'b1;
                    mode_d     = mode_eff_c;
                    len_d      = len;
                    sr_d       = {opcode_c, addr};
                    cnt_d      = '0;
                    phase_d    = 1'b0;
                    byte_cnt_d = '0;
                end
            end
            S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
                if (csn_q) begin
                    csn_d   = 1'b0;
                    io_o_d  = {3'b000, sr_q[SR_W-1]};
                    io_oe_d = 4'b0001;
                end else if (!phase_q) begin
                    // Hold SCK low at a byte boundary while the consumer is stalled
                    if (!(state_q == S_DATA && cnt_q == '0 && rd_valid_q && !rd_ready)) begin
                        phase_d = 1'b1;
                        sck_d   = 1'b1;
                    end
                end else begin
                    phase_d = 1'b0;
                    sck_d   = 1'b0;
                    cnt_d   = cnt_q + CNT_W'(1);
                    case (state_q)
                        S_CMD: begin
                            sr_d   = sr_shift_c;
                            io_o_d = {3'b000, sr_shift_c[SR_W-1]};
                            if (cnt_q == CNT_W'(7)) begin
                                state_d = S_ADDR;
                                cnt_d   = '0;
                            end
                        end
                        S_ADDR: begin
                            sr_d   = sr_shift_c;
                            io_o_d = {3'b000, sr_shift_c[SR_W-1]};
                            if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                                state_d = (mode_q == 2'd0) ? S_DATA : S_DUMMY;
                                cnt_d   = '0;
                                io_o_d  = 4'b0000;
                                io_oe_d = 4'b0000;
                            end
                        end
                        S_DUMMY: begin
                            if (cnt_q == CNT_W'(DUMMY_CYC - 1)) begin
                                state_d = S_DATA;
                                cnt_d   = '0;
                            end
                        end
                        default: begin
                            rx_d = rx_shift_c[6:0];
                            if (cnt_q == bpb_last_c) begin
                                cnt_d      = '0;
                                rd_data_d  = rx_shift_c;
                                rd_valid_d = 1'b1;
                                byte_cnt_d = byte_cnt_q + LEN_W'(1);
                                if (byte_cnt_q == len_q) begin
                                    state_d = S_END;
                                    csn_d   = 1'b1;
                                end
                            end
                        end
                    endcase
                end
            end
            S_END: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(CSN_HOLD - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge qspi_clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            phase_q    <= 1'b0;
            cnt_q      <= '0;
            sr_q       <= '0;
            mode_q     <= '0;
            len_q      <= '0;
            byte_cnt_q <= '0;
            rx_q       <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sck_q      <= 1'b0;
            csn_q      <= 1'b1;
            io_o_q     <= '0;
            io_oe_q    <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            mode_q     <= mode_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            rx_q       <= rx_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sck_q      <= sck_d;
            csn_q      <= csn_d;
            io_o_q     <= io_o_d;
            io_oe_q    <= io_oe_d;
        end
    end

    assign ack      = ack_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign sck      = sck_q;
    assign csn      = csn_q;
    assign io_o     = io_o_q;
    assign io_oe    = io_oe_q;

endmodule

// File: tb/tb_qspi_read_master.sv
// Directed bench for qspi_read_master with a behavioural SPI flash on the pads.
module tb_qspi_read_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [23:0] addr = '0;
    logic [7:0]  len = '0;
    logic        ack, busy, done, rd_valid, sck, csn;
    logic [7:0]  rd_data;
    logic        rd_ready = 1'b1;
    logic [3:0]  io_o, io_oe;
    logic [3:0]  io_i = 4'h0;

    qspi_read_master dut (
        .qspi_clk (clk),
        .rst      (rst),
        .req      (req),
        .mode     (mode),
        .addr     (addr),
        .len      (len),
        .ack      (ack),
        .busy     (busy),
        .done     (done),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .sck      (sck),
        .csn      (csn),
        .io_o     (io_o),
        .io_oe    (io_oe),
        .io_i     (io_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Flash model: records opcode+address, drives read data on each SCK rise
    logic [7:0]  fl_data [0:255];
    int          fl_lanes = 1;
    int          fl_dummy = 0;
    int          fl_sck   = 0;
    int          fl_j;
    logic [7:0]  fl_chunk;
    logic [31:0] fl_cmdaddr = '0;
    logic [3:0]  fl_oe_cmd  = '0;
    logic [3:0]  fl_oe_rest = '0;

    always @(posedge sck or negedge csn) begin
        if (!sck) begin
            fl_sck     = 0;
            fl_cmdaddr = '0;
            fl_oe_cmd  = '0;
            fl_oe_rest = '0;
        end else begin
            if (fl_sck < 32) begin
                fl_cmdaddr = {fl_cmdaddr[30:0], io_o[0]};
                fl_oe_cmd  = fl_oe_cmd | io_oe;
            end else begin
                fl_oe_rest = fl_oe_rest | io_oe;
            end
            fl_j = fl_sck - 32 - fl_dummy;
            if (fl_j >= 0) begin
                fl_chunk = fl_data[(fl_j / (8 / fl_lanes)) % 256]
                           >> (8 - fl_lanes * ((fl_j % (8 / fl_lanes)) + 1));
                if (fl_lanes == 1)      io_i = {2'b00, fl_chunk[0], ~fl_chunk[0]};
                else if (fl_lanes == 2) io_i = {2'b11, fl_chunk[1:0]};
                else                    io_i = fl_chunk[3:0];
            end
            fl_sck = fl_sck + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] got [0:255];
    int         vcyc [0:255];
    int         nbytes, first_lat, end_hold, extra_acks, timeouts;
    logic       stall_ok;

    // One transaction: request, collect bytes with optional stall on byte 0
    task automatic run_txn(input logic [1:0] m, input logic [23:0] a, input logic [7:0] l,
                           input int stall, input logic poke);
        int t_ack, guard, stalled;
        logic [7:0] held;
        mode = m; addr = a; len = l; req = 1'b1; rd_ready = 1'b1;
        guard = 0;
        while (!ack && guard < 50) begin
            tick();
            guard = guard + 1;
        end
        req = 1'b0;
        t_ack = cyc;
        if (!ack) timeouts = timeouts + 1;
        nbytes = 0; first_lat = -1; end_hold = 0; extra_acks = 0;
        stalled = 0; stall_ok = 1'b1; held = '0;
        guard = 0;
        while (!done && guard < 5000) begin
            if (ack && cyc > t_ack) extra_acks = extra_acks + 1;
            if (rd_valid && first_lat < 0) first_lat = cyc - t_ack;
            if (csn && busy && first_lat >= 0) end_hold = end_hold + 1;
            if (rd_valid && nbytes == 0 && stalled < stall) begin
                if (stalled == 0) held = rd_data;
                if (sck !== 1'b0 || rd_data !== held || rd_valid !== 1'b1) stall_ok = 1'b0;
                rd_ready = 1'b0;
                stalled = stalled + 1;
            end else begin
                rd_ready = 1'b1;
            end
            if (rd_valid && rd_ready) begin
                got[nbytes % 256]  = rd_data;
                vcyc[nbytes % 256] = cyc;
                nbytes = nbytes + 1;
            end
            req = poke && (cyc - t_ack >= 10) && (cyc - t_ack < 40);
            tick();
            guard = guard + 1;
        end
        req = 1'b0;
        rd_ready = 1'b1;
        if (!done) timeouts = timeouts + 1;
    endtask

    int gap_bad, cmp_bad, guard0;

    initial begin
        timeouts = 0;
        // Reset state
        repeat (3) tick();
        check("reset_pads", {csn, sck, io_o, io_oe}, {1'b1, 1'b0, 4'h0, 4'h0});
        check("reset_ctrl", {ack, busy, done, rd_valid, rd_data}, '0);
        rst = 1'b0;
        tick();

        // Mode 0 READ, two bytes
        fl_lanes = 1; fl_dummy = 0;
        fl_data[0] = 8'hA5; fl_data[1] = 8'h3C;
        run_txn(2'd0, 24'h000100, 8'd1, 0, 1'b0);
        check("m0_cmdaddr", fl_cmdaddr, 32'h03000100);
        check("m0_oe_cmd", fl_oe_cmd, 4'b0001);
        check("m0_oe_data", fl_oe_rest, 4'b0000);
        check("m0_latency", first_lat, 81);
        check("m0_count", nbytes, 2);
        check("m0_bytes", {got[0], got[1]}, 16'hA53C);
        check("m0_csn_hold", end_hold, 4);
        check("m0_idle", {done, busy, csn, sck}, {1'b1, 1'b0, 1'b1, 1'b0});

        // Mode 1 FAST_READ with dummy cycles
        fl_dummy = 8;
        fl_data[0] = 8'h5A;
        run_txn(2'd1, 24'h123456, 8'd0, 0, 1'b0);
        check("m1_cmdaddr", fl_cmdaddr, 32'h0B123456);
        check("m1_oe_dummy", fl_oe_rest, 4'b0000);
        check("m1_latency", first_lat, 97);
        check("m1_byte", {nbytes[7:0], got[0]}, {8'd1, 8'h5A});

        // Mode 2 dual output, four bytes spaced 8 cycles
        fl_lanes = 2;
        fl_data[0] = 8'h11; fl_data[1] = 8'h22; fl_data[2] = 8'h33; fl_data[3] = 8'h44;
        run_txn(2'd2, 24'hABCDEF, 8'd3, 0, 1'b0);
        check("m2_cmdaddr", fl_cmdaddr, 32'h3BABCDEF);
        check("m2_latency", first_lat, 89);
        check("m2_bytes", {nbytes[7:0], got[0], got[1], got[2], got[3]}, 40'h04_11223344);
        gap_bad = 0;
        for (int i = 0; i < 3; i++) if (vcyc[i+1] - vcyc[i] != 8) gap_bad = gap_bad + 1;
        check("m2_spacing", gap_bad, 0);

        // Mode 3: quad when enabled, else falls back to dual
`ifdef QSPI_QUAD_EN
        fl_lanes = 4;
`else
        fl_lanes = 2;
`endif
        fl_data[0] = 8'hF0;
        run_txn(2'd3, 24'h000040, 8'd0, 0, 1'b0);
`ifdef QSPI_QUAD_EN
        check("m3_cmdaddr", fl_cmdaddr, 32'h6B000040);
        check("m3_latency", first_lat, 85);
`else
        check("m3_cmdaddr", fl_cmdaddr, 32'h3B000040);
        check("m3_latency", first_lat, 89);
`endif
        check("m3_byte", got[0], 8'hF0);
        check("m3_oe", {fl_oe_cmd, fl_oe_rest}, 8'h10);

        // Backpressure: byte 0 held 20 cycles in mode 0
        fl_lanes = 1; fl_dummy = 0;
        fl_data[0] = 8'h77; fl_data[1] = 8'h88; fl_data[2] = 8'h99;
        run_txn(2'd0, 24'h000200, 8'd2, 20, 1'b0);
        check("bp_frozen", stall_ok, 1'b1);
        check("bp_bytes", {nbytes[7:0], got[0], got[1], got[2]}, 32'h03_778899);

        // Reset in the middle of the address phase
        mode = 2'd0; addr = 24'hFFFFFF; len = 8'd5; req = 1'b1;
        guard0 = 0;
        while (!ack && guard0 < 50) begin
            tick();
            guard0 = guard0 + 1;
        end
        req = 1'b0;
        repeat (25) tick();
        check("addr_active", {csn, busy}, {1'b0, 1'b1});
        #2 rst = 1'b1;
        #1;
        check("rst_abort", {csn, sck, busy, rd_valid}, {1'b1, 1'b0, 1'b0, 1'b0});
        @(negedge clk) rst = 1'b0;
        tick();

        // Normal transaction afterwards, with req poked while busy
        fl_data[0] = 8'hC3; fl_data[1] = 8'h69;
        run_txn(2'd0, 24'h000100, 8'd1, 0, 1'b1);
        check("post_rst_bytes", {nbytes[7:0], got[0], got[1]}, 24'h02_C369);
        check("post_rst_latency", first_lat, 81);
        check("busy_req_no_ack", extra_acks, 0);

        // len all ones: 256 bytes
        for (int i = 0; i < 256; i++) fl_data[i] = 8'(i) ^ 8'h5A;
`ifdef QSPI_QUAD_EN
        fl_lanes = 4;
`else
        fl_lanes = 2;
`endif
        fl_dummy = 8;
        run_txn(2'd3, 24'h001000, 8'hFF, 0, 1'b0);
        check("full_count", nbytes, 256);
        cmp_bad = 0;
        for (int i = 0; i < 256; i++) if (got[i] !== (8'(i) ^ 8'h5A)) cmp_bad = cmp_bad + 1;
        check("full_data", cmp_bad, 0);

        check("no_timeouts", timeouts, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
